// File: rtl/qdma_tm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qdma_tm_pkg
//  Description : Definitions shared by the QDMA example-design traffic
//                generator and checker blocks. It holds the checker state
//                encoding, the bit positions used in control_reg, and helpers
//                that derive pattern lanes and beat counts.
//  Revision    : 1.0 - initial release
// ============================================================================
package qdma_tm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tm_state_e;

   // Bit positions within control_reg
   localparam int unsigned CTRL_START      = 1;
   localparam int unsigned CTRL_BACKPRES   = 2;
   localparam int unsigned CTRL_CONTINUOUS = 10;

   // Number of pattern lanes carried in one data beat
   function automatic int unsigned lanes_per_beat(input int unsigned bit_width,
                                                  input int unsigned patt_width);
      return bit_width / patt_width;
   endfunction

   // Beats needed to carry 'size' bytes. A zero-byte transfer still
   // occupies one beat.
   function automatic logic [15:0] beats_for_size(input logic [15:0]   size,
                                                  input int unsigned bpb);
      int unsigned n;
      n = (32'(size) + bpb - 32'd1) / bpb;
      if (size == 16'd0) n = 32'd1;
      return n[15:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/st_patt_gen.sv
`default_nettype none
// ============================================================================
//  Module      : st_patt_gen
//  Description : Incrementing lane-pattern source. It holds one register per
//                pattern lane. After a restart, lane j holds continue_from + j.
//                Each advance adds the lane count to every lane, with
//                arithmetic modulo 2^PATT_WIDTH. Restart has priority over
//                advance.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                restart             - reload lanes from continue_from
//                advance             - step every lane by the lane count
//                continue_from       - lane-0 value applied on restart
//                lanes               - packed lane values, lane 0 in LSBs
//  Revision    : 1.0 - initial release
// ============================================================================
module st_patt_gen
   import qdma_tm_pkg::*;
#(
   parameter int BIT_WIDTH  = 64,
   parameter int PATT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  restart,
   input  logic                  advance,
   input  logic [PATT_WIDTH-1:0] continue_from,
   output logic [BIT_WIDTH-1:0]  lanes
);

   localparam int LANES = int'(lanes_per_beat(BIT_WIDTH, PATT_WIDTH));

   logic [PATT_WIDTH-1:0] lane_q [LANES];

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      always_ff @(posedge clk) begin
         if (rst) begin
            lane_q[j] <= PATT_WIDTH'(j);
         end else if (restart) begin
            lane_q[j] <= continue_from + PATT_WIDTH'(j);
         end else if (advance) begin
            lane_q[j] <= lane_q[j] + PATT_WIDTH'(LANES);
         end
      end
      assign lanes[j*PATT_WIDTH +: PATT_WIDTH] = lane_q[j];
   end

endmodule
`default_nettype wire

// File: rtl/st_h2c_checker.sv
`default_nettype none
// ============================================================================
//  Module      : st_h2c_checker
//  Description : H2C AXI-Stream traffic checker. It consumes host-written
//                packets that carry the incrementing lane pattern, and checks
//                lane data, per-byte odd parity and packet length. It counts
//                packets and reports sticky status.
//  Config      : ST_H2C_PARITY_CHK_EN - when defined, per-byte odd parity is
//                checked on valid bytes and drives err_par. When undefined,
//                h2c_dpar is ignored and err_par is tied to 0.
//  Ports       : axi_aclk, axi_areset - clock, synchronous active-high reset
//                control_reg  - [1] start (rising edge), [2] back-pressure,
//                               [10] continuous pattern across packets
//                txr_size     - bytes per packet
//                num_pkt      - packets expected per run
//                h2c_*        - AXI-Stream slave (tdata/dpar/tvalid/tlast/tready)
//                chk_busy     - checker running
//                chk_done     - run finished (sticky)
//                err_data/err_len/err_par - sticky error flags
//                pkt_count    - packets completed this run
//                err_beat     - global beat index of first error, FFFF if none
//  Revision    : 1.0 - initial release
// ============================================================================
module st_h2c_checker
   import qdma_tm_pkg::*;
#(
   parameter int BIT_WIDTH  = 64,
   parameter int PATT_WIDTH = 16
) (
   input  logic                   axi_aclk,
   input  logic                   axi_areset,
   input  logic [31:0]            control_reg,
   input  logic [15:0]            txr_size,
   input  logic [10:0]            num_pkt,
   input  logic [BIT_WIDTH-1:0]   h2c_tdata,
   input  logic [BIT_WIDTH/8-1:0] h2c_dpar,
   input  logic                   h2c_tvalid,
   input  logic                   h2c_tlast,
   output logic                   h2c_tready,
   output logic                   chk_busy,
   output logic                   chk_done,
   output logic                   err_data,
   output logic                   err_len,
   output logic                   err_par,
   output logic [10:0]            pkt_count,
   output logic [15:0]            err_beat
);

   localparam int BPB        = BIT_WIDTH / 8;
   localparam int LANES      = int'(lanes_per_beat(BIT_WIDTH, PATT_WIDTH));
   localparam int BSH        = $clog2(BPB);
   localparam int LANE_BYTES = PATT_WIDTH / 8;
   localparam int LSH        = $clog2(LANE_BYTES);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_RUN  = RUN;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]            state;
   logic                  start_s1;
   logic                  start_s2;
   logic                  start_edge;
   logic                  bp_phase;
   logic [15:0]           beat_in_pkt;
   logic [15:0]           beat_glb;
   logic [15:0]           beat_in_pkt_nxt;
   logic [15:0]           exp_beats;
   logic [BSH-1:0]        vbl;
   logic                  vbl_nz;
   logic                  beat_acc;
   logic [BIT_WIDTH-1:0]  exp_data;
   logic [BPB-1:0]        byte_chk;
   logic [BPB-1:0]        data_bad_b;
   logic                  data_bad;
   logic                  par_bad;
   logic                  len_bad;
   logic                  any_bad;
   logic                  err_par_q;
   logic [PATT_WIDTH-1:0] cont_lanes;
   logic [PATT_WIDTH-1:0] patt_from;
   logic                  patt_restart;
   logic                  patt_advance;
   logic                  unused_ctrl;

   assign unused_ctrl = ^{control_reg[31:11], control_reg[9:3], control_reg[0]};

   // A start edge is seen one cycle after bit 1 is sampled, so tready opens
   // two cycles after the bit rises.
   assign start_edge = start_s1 & ~start_s2;

   assign chk_busy   = (state == S_RUN);
   assign chk_done   = (state == S_DONE);
   assign h2c_tready = (state == S_RUN) & (~control_reg[CTRL_BACKPRES] | bp_phase);

   // A start edge in the same cycle as a beat restarts the run and drops
   // the beat.
   assign beat_acc = h2c_tvalid & h2c_tready & ~start_edge;

   assign exp_beats       = beats_for_size(txr_size, BPB);
   assign vbl             = txr_size[BSH-1:0];
   assign vbl_nz          = (vbl != '0);
   assign beat_in_pkt_nxt = beat_in_pkt + 16'd1;

   // Only the tlast beat of a packet may be partial. Bytes at or above the
   // residue are not checked there.
   for (genvar b = 0; b < BPB; b++) begin : g_byte
      assign byte_chk[b]   = ~h2c_tlast | ~vbl_nz | (BSH'(b) < vbl);
      assign data_bad_b[b] = byte_chk[b] & (h2c_tdata[b*8 +: 8] != exp_data[b*8 +: 8]);
   end
   assign data_bad = |data_bad_b;

`ifdef ST_H2C_PARITY_CHK_EN
   logic [BPB-1:0] par_bad_b;
   for (genvar b = 0; b < BPB; b++) begin : g_par
      assign par_bad_b[b] = byte_chk[b] & (h2c_dpar[b] != ~^h2c_tdata[b*8 +: 8]);
   end
   assign par_bad = |par_bad_b;

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         err_par_q <= 1'b0;
      end else if (start_edge) begin
         err_par_q <= 1'b0;
      end else if (beat_acc && par_bad) begin
         err_par_q <= 1'b1;
      end
   end
`else
   logic unused_dpar;
   assign unused_dpar = ^h2c_dpar;
   assign par_bad     = 1'b0;
   assign err_par_q   = 1'b0;
`endif
   assign err_par = err_par_q;

   // Flag an error on an early tlast, or when the expected last beat arrives
   // without tlast.
   assign len_bad = h2c_tlast ? (beat_in_pkt_nxt != exp_beats)
                              : (beat_in_pkt_nxt == exp_beats);
   assign any_bad = data_bad | par_bad | len_bad;

   // Count of lanes that hold at least one valid byte on the tlast beat. In
   // continuous mode the next packet starts at lane0 + this count, which is
   // the last valid lane value plus one.
   always_comb begin
      cont_lanes = PATT_WIDTH'(LANES);
      if (vbl_nz) begin
         cont_lanes = PATT_WIDTH'((32'(vbl) + 32'(LANE_BYTES - 1)) >> LSH);
      end
   end

   always_comb begin
      patt_from = '0;
      if (!start_edge && control_reg[CTRL_CONTINUOUS]) begin
         patt_from = exp_data[PATT_WIDTH-1:0] + cont_lanes;
      end
   end

   assign patt_restart = start_edge | (beat_acc & h2c_tlast);
   assign patt_advance = beat_acc & ~h2c_tlast;

   st_patt_gen #(
      .BIT_WIDTH  (BIT_WIDTH),
      .PATT_WIDTH (PATT_WIDTH)
   ) u_patt (
      .clk           (axi_aclk),
      .rst           (axi_areset),
      .restart       (patt_restart),
      .advance       (patt_advance),
      .continue_from (patt_from),
      .lanes         (exp_data)
   );

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         state       <= S_IDLE;
         start_s1    <= 1'b0;
         start_s2    <= 1'b0;
         bp_phase    <= 1'b0;
         beat_in_pkt <= '0;
         beat_glb    <= '0;
         pkt_count   <= '0;
         err_data    <= 1'b0;
         err_len     <= 1'b0;
         err_beat    <= 16'hFFFF;
      end else begin
         start_s1 <= control_reg[CTRL_START];
         start_s2 <= start_s1;
         bp_phase <= ~bp_phase;
         if (start_edge) begin
            // bp_phase = 1 makes the first RUN cycle ready.
            bp_phase    <= 1'b1;
            beat_in_pkt <= '0;
            beat_glb    <= '0;
            pkt_count   <= '0;
            err_data    <= 1'b0;
            err_len     <= 1'b0;
            err_beat    <= 16'hFFFF;
            state       <= (num_pkt == 11'd0) ? S_DONE : S_RUN;
         end else if (beat_acc) begin
            beat_glb <= beat_glb + 16'd1;
            if (data_bad) err_data <= 1'b1;
            if (len_bad)  err_len  <= 1'b1;
            if (any_bad && !(err_data || err_len || err_par_q)) begin
               err_beat <= beat_glb;
            end
            if (h2c_tlast) begin
               beat_in_pkt <= '0;
               pkt_count   <= pkt_count + 11'd1;
               if ((pkt_count + 11'd1) == num_pkt) begin
                  state <= S_DONE;
               end
            end else begin
               beat_in_pkt <= beat_in_pkt_nxt;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_st_h2c_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_st_h2c_checker
//  Description : Bench for st_h2c_checker with BIT_WIDTH=64 and
//                PATT_WIDTH=16. It runs directed scenarios and randomized
//                runs against a lane-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_st_h2c_checker;

`ifdef ST_H2C_PARITY_CHK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        axi_areset = 1'b1;
   logic [31:0] control_reg = '0;
   logic [15:0] txr_size = '0;
   logic [10:0] num_pkt = '0;
   logic [63:0] h2c_tdata = '0;
   logic [7:0]  h2c_dpar = '0;
   logic        h2c_tvalid = 1'b0;
   logic        h2c_tlast = 1'b0;
   logic        h2c_tready;
   logic        chk_busy, chk_done, err_data, err_len, err_par;
   logic [10:0] pkt_count;
   logic [15:0] err_beat;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   logic [15:0] m_base;
   int          m_gbeat;
   bit          m_err_data, m_err_par, m_err_len;
   logic [15:0] m_err_beat;
   bit          m_cont;

   always #5 clk = ~clk;

   st_h2c_checker #(.BIT_WIDTH(64), .PATT_WIDTH(16)) dut (
      .axi_aclk(clk), .axi_areset(axi_areset), .control_reg(control_reg),
      .txr_size(txr_size), .num_pkt(num_pkt), .h2c_tdata(h2c_tdata),
      .h2c_dpar(h2c_dpar), .h2c_tvalid(h2c_tvalid), .h2c_tlast(h2c_tlast),
      .h2c_tready(h2c_tready), .chk_busy(chk_busy), .chk_done(chk_done),
      .err_data(err_data), .err_len(err_len), .err_par(err_par),
      .pkt_count(pkt_count), .err_beat(err_beat)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // lane j of beat k in a packet starting at base = base + 4k + j
   function automatic logic [63:0] patt(input logic [15:0] base, input int k);
      logic [63:0] r;
      for (int j = 0; j < 4; j++) r[j*16 +: 16] = base + 16'(k*4 + j);
      return r;
   endfunction

   function automatic logic [7:0] par_of(input logic [63:0] d);
      logic [7:0] p;
      for (int b = 0; b < 8; b++) p[b] = ~^d[b*8 +: 8];
      return p;
   endfunction

   task automatic send_beat(input logic [63:0] d, input logic [7:0] p, input bit last);
      int guard = 0;
      h2c_tdata = d; h2c_dpar = p; h2c_tlast = last; h2c_tvalid = 1'b1;
      while (!h2c_tready && guard < 50) begin
         step();
         guard++;
      end
      if (!h2c_tready) begin
         n_checks++;
         $display("FAIL beat_timeout: tready=%0b after %0d cycles, required 1", h2c_tready, guard);
      end
      step();
      h2c_tvalid = 1'b0; h2c_tlast = 1'b0;
   endtask

   task automatic model_clear();
      m_base = '0; m_gbeat = 0; m_err_beat = 16'hFFFF;
      m_err_data = 0; m_err_par = 0; m_err_len = 0;
   endtask

   // Re-arms the checker by lowering and then raising start.
   task automatic arm();
      control_reg[1] = 1'b0;
      step();
      control_reg[1] = 1'b1;
      step();
      step();
      model_clear();
   endtask

   // Drives one packet of nbeats beats and updates the model.
   task automatic send_pkt(input int size, input int nbeats, input int bad_beat,
                           input int bad_byte, input bit bad_par, input logic [7:0] bad_xor);
      int eb, vbl, vb;
      logic [63:0] d;
      logic [7:0]  p;
      bit last, e_d, e_p, e_l;
      eb  = (size == 0) ? 1 : (size + 7) / 8;
      vbl = size % 8;
      for (int k = 0; k < nbeats; k++) begin
         last = (k == nbeats - 1);
         vb   = (last && vbl != 0) ? vbl : 8;
         d    = patt(m_base, k);
         for (int b = vb; b < 8; b++) d[b*8 +: 8] = 8'($urandom);
         p = par_of(d);
         for (int b = vb; b < 8; b++) p[b] = 1'($urandom);
         e_d = 0; e_p = 0;
         if (k == bad_beat) begin
            if (bad_par) begin
               p[bad_byte] = ~p[bad_byte];
               e_p = PAR_EN && (bad_byte < vb);
            end else begin
               d[bad_byte*8 +: 8] = d[bad_byte*8 +: 8] ^ bad_xor;
               e_d = (bad_byte < vb) && (bad_xor != 8'd0);
            end
         end
         e_l = last ? (k + 1 != eb) : (k + 1 == eb);
         if ((e_d || e_p || e_l) && m_err_beat == 16'hFFFF) m_err_beat = 16'(m_gbeat);
         m_err_data |= e_d; m_err_par |= e_p; m_err_len |= e_l;
         m_gbeat++;
         send_beat(d, p, last);
      end
      if (m_cont) m_base = m_base + 16'((nbeats - 1) * 4 + ((vbl == 0) ? 4 : (vbl + 1) / 2));
      else        m_base = '0;
   endtask

   task automatic test_reset();
      axi_areset = 1'b1;
      repeat (4) step();
      axi_areset = 1'b0;
      step();
      n_checks++; if (h2c_tready !== 1'b0) $display("FAIL rst_tready got=%0b req=0", h2c_tready); else n_pass++;
      n_checks++; if (err_beat !== 16'hFFFF) $display("FAIL rst_err_beat got=%0h req=ffff", err_beat); else n_pass++;
      n_checks++; if ({chk_busy, chk_done, err_data, err_len, err_par} !== 5'b0)
         $display("FAIL rst_flags got=%b req=00000", {chk_busy, chk_done, err_data, err_len, err_par}); else n_pass++;
      n_checks++; if (pkt_count !== 11'd0) $display("FAIL rst_pkt_count got=%0d req=0", pkt_count); else n_pass++;
   endtask

   task automatic test_clean_run();
      control_reg = '0; m_cont = 0; txr_size = 16'd20; num_pkt = 11'd2;
      step();
      control_reg[1] = 1'b1;
      step();
      n_checks++; if (h2c_tready !== 1'b0) $display("FAIL start_lat1 tready got=%0b req=0", h2c_tready); else n_pass++;
      step();
      n_checks++; if (h2c_tready !== 1'b1) $display("FAIL start_lat2 tready got=%0b req=1", h2c_tready); else n_pass++;
      n_checks++; if (chk_busy !== 1'b1) $display("FAIL start_busy got=%0b req=1", chk_busy); else n_pass++;
      model_clear();
      send_pkt(20, 3, -1, 0, 0, 8'd0);
      send_pkt(20, 3, -1, 0, 0, 8'd0);
      n_checks++; if (pkt_count !== 11'd2) $display("FAIL clean_pkt_count got=%0d req=2", pkt_count); else n_pass++;
      n_checks++; if (chk_done !== 1'b1 || h2c_tready !== 1'b0)
         $display("FAIL clean_done got=%0b/%0b req=1/0", chk_done, h2c_tready); else n_pass++;
      n_checks++; if ({err_data, err_len, err_par} !== 3'b0)
         $display("FAIL clean_errs got=%b req=000", {err_data, err_len, err_par}); else n_pass++;
      n_checks++; if (err_beat !== 16'hFFFF) $display("FAIL clean_err_beat got=%0h req=ffff", err_beat); else n_pass++;
   endtask

   task automatic test_data_error();
      logic [63:0] d;
      control_reg = '0; txr_size = 16'd20; num_pkt = 11'd1;
      arm();
      d = patt(16'd0, 0);
      send_beat(d, par_of(d), 1'b0);
      n_checks++; if (err_data !== 1'b0) $display("FAIL data_pre got=%0b req=0", err_data); else n_pass++;
      d = patt(16'd0, 1);
      d[31:16] = 16'd6;
      send_beat(d, par_of(d), 1'b0);
      n_checks++; if (err_data !== 1'b1) $display("FAIL data_err got=%0b req=1", err_data); else n_pass++;
      n_checks++; if (err_beat !== 16'd1) $display("FAIL data_err_beat got=%0d req=1", err_beat); else n_pass++;
      d = patt(16'd0, 2);
      send_beat(d, par_of(d), 1'b1);
      n_checks++; if ({chk_done, err_len, err_par} !== 3'b100)
         $display("FAIL data_tail got=%b req=100", {chk_done, err_len, err_par}); else n_pass++;
   endtask

   task automatic test_len_error();
      control_reg = '0; m_cont = 0; txr_size = 16'd16; num_pkt = 11'd2;
      arm();
      send_pkt(16, 1, -1, 0, 0, 8'd0);
      n_checks++; if (err_len !== 1'b1) $display("FAIL len_err got=%0b req=1", err_len); else n_pass++;
      n_checks++; if (pkt_count !== 11'd1) $display("FAIL len_pkt_count got=%0d req=1", pkt_count); else n_pass++;
      n_checks++; if (err_beat !== 16'd0 || chk_done !== 1'b0)
         $display("FAIL len_beat_done got=%0d/%0b req=0/0", err_beat, chk_done); else n_pass++;
   endtask

   task automatic test_parity();
      control_reg = '0; m_cont = 0; txr_size = 16'd16; num_pkt = 11'd1;
      arm();
      send_pkt(16, 2, 0, 3, 1'b1, 8'd0);
      n_checks++; if (err_par !== PAR_EN) $display("FAIL par_err got=%0b req=%0b", err_par, PAR_EN); else n_pass++;
      n_checks++; if (err_data !== 1'b0 || chk_done !== 1'b1)
         $display("FAIL par_side got=%0b/%0b req=0/1", err_data, chk_done); else n_pass++;
   endtask

   task automatic test_backpressure_cont();
      control_reg = '0; control_reg[2] = 1'b1; control_reg[10] = 1'b1; m_cont = 1;
      txr_size = 16'd12; num_pkt = 11'd2;
      arm();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (h2c_tready !== 1'((i + 1) % 2)) $display("FAIL bp_toggle%0d got=%0b req=%0b", i, h2c_tready, (i + 1) % 2);
         else n_pass++;
         step();
      end
      send_pkt(12, 2, -1, 0, 0, 8'd0);
      send_pkt(12, 2, -1, 0, 0, 8'd0);
      n_checks++; if (chk_done !== 1'b1 || pkt_count !== 11'd2)
         $display("FAIL bp_done got=%0b/%0d req=1/2", chk_done, pkt_count); else n_pass++;
      n_checks++; if ({err_data, err_len, err_par} !== 3'b0)
         $display("FAIL bp_cont_errs got=%b req=000", {err_data, err_len, err_par}); else n_pass++;
      control_reg[2] = 1'b0; control_reg[10] = 1'b0; m_cont = 0;
   endtask

   task automatic test_num_pkt_zero();
      num_pkt = 11'd0; txr_size = 16'd8;
      arm();
      n_checks++; if (chk_done !== 1'b1 || h2c_tready !== 1'b0 || chk_busy !== 1'b0)
         $display("FAIL zero_pkt got=%b req=100", {chk_done, h2c_tready, chk_busy}); else n_pass++;
      n_checks++; if (pkt_count !== 11'd0) $display("FAIL zero_pkt_count got=%0d req=0", pkt_count); else n_pass++;
   endtask

   task automatic test_restart_mid_run();
      logic [63:0] d;
      control_reg = '0; m_cont = 0; txr_size = 16'd20; num_pkt = 11'd1;
      arm();
      d = patt(16'd0, 0);
      send_beat(d, par_of(d), 1'b0);
      arm();
      send_pkt(20, 3, -1, 0, 0, 8'd0);
      n_checks++; if (chk_done !== 1'b1 || pkt_count !== 11'd1)
         $display("FAIL restart_done got=%0b/%0d req=1/1", chk_done, pkt_count); else n_pass++;
      n_checks++; if ({err_data, err_len, err_par} !== 3'b0 || err_beat !== 16'hFFFF)
         $display("FAIL restart_errs got=%b/%0h req=000/ffff", {err_data, err_len, err_par}, err_beat); else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      logic [63:0] d;
      control_reg = '0; txr_size = 16'd20; num_pkt = 11'd2;
      arm();
      d = patt(16'd0, 0);
      send_beat(d, par_of(d) ^ 8'h01, 1'b0);
      d = patt(16'd0, 1);
      h2c_tdata = d; h2c_dpar = par_of(d); h2c_tvalid = 1'b1;
      axi_areset = 1'b1; control_reg[1] = 1'b0;
      step();
      axi_areset = 1'b0; h2c_tvalid = 1'b0;
      n_checks++; if ({h2c_tready, chk_busy, chk_done, err_data, err_len, err_par} !== 6'b0)
         $display("FAIL midrst_flags got=%b req=000000", {h2c_tready, chk_busy, chk_done, err_data, err_len, err_par}); else n_pass++;
      n_checks++; if (err_beat !== 16'hFFFF || pkt_count !== 11'd0)
         $display("FAIL midrst_cnt got=%0h/%0d req=ffff/0", err_beat, pkt_count); else n_pass++;
      step();
      n_checks++; if (chk_busy !== 1'b0) $display("FAIL midrst_idle got=%0b req=0", chk_busy); else n_pass++;
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         int np, sz, eb, nb, bb;
         np = int'($urandom_range(1, 3));
         sz = int'($urandom_range(0, 40));
         m_cont = 1'($urandom_range(0, 1));
         control_reg = '0;
         control_reg[2]  = 1'($urandom_range(0, 1));
         control_reg[10] = m_cont;
         txr_size = 16'(sz); num_pkt = 11'(np);
         arm();
         for (int p = 0; p < np; p++) begin
            eb = (sz == 0) ? 1 : (sz + 7) / 8;
            nb = eb;
            if ($urandom_range(0, 5) == 0) nb = (eb > 1 && $urandom_range(0, 1) == 1) ? eb - 1 : eb + 1;
            bb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 32'(nb - 1))) : -1;
            send_pkt(sz, nb, bb, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(1, 255)));
         end
         n_checks++; if (chk_done !== 1'b1 || pkt_count !== 11'(np))
            $display("FAIL rnd%0d_done got=%0b/%0d req=1/%0d", r, chk_done, pkt_count, np); else n_pass++;
         n_checks++; if ({err_data, err_len, err_par} !== {m_err_data, m_err_len, m_err_par})
            $display("FAIL rnd%0d_errs got=%b req=%b", r, {err_data, err_len, err_par},
                     {m_err_data, m_err_len, m_err_par}); else n_pass++;
         n_checks++; if (err_beat !== m_err_beat)
            $display("FAIL rnd%0d_err_beat got=%0d req=%0d", r, err_beat, m_err_beat); else n_pass++;
      end
   endtask

   initial begin
      model_clear();
      m_cont = 0;
      test_reset();
      test_clean_run();
      test_data_error();
      test_len_error();
      test_parity();
      test_backpressure_cont();
      test_num_pkt_zero();
      test_restart_mid_run();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/st_h2c_checker.md
# st_h2c_checker

Host-to-card AXI-Stream traffic checker for the QDMA example design. It sits on the H2C stream output of the DMA and consumes packets written by the host. The host writes these packets with the same incrementing PATT_WIDTH lane pattern that the C2H traffic generator emits. It verifies per-lane data, per-byte parity and packet length, counts packets, and reports sticky pass/fail status to the control-register block.

## Interface
- BIT_WIDTH, 64: H2C tdata width; legal values 64/128/256/512.
- PATT_WIDTH, 16: pattern lane width; legal values 16/32.
- axi_aclk  in  1  clock.
- axi_areset  in  1  reset, synchronous, active-high.
- control_reg  in  32  control bits:
  - [1] start; rising edge arms the checker.
  - [2] back-pressure mode.
  - [10] continuous pattern across packets.
- txr_size  in  16  bytes per packet.
- num_pkt  in  11  packets expected per run.
- h2c_tdata  in  BIT_WIDTH  stream data.
- h2c_dpar  in  BIT_WIDTH/8  odd parity per byte: bit = ~^byte.
- h2c_tvalid  in  1  beat valid.
- h2c_tlast  in  1  last beat of packet.
- h2c_tready  out  1  beat accept.
- chk_busy  out  1  checker in RUN.
- chk_done  out  1  sticky; run finished.
- err_data  out  1  sticky; lane mismatch.
- err_len  out  1  sticky; beat count ≠ expected.
- err_par  out  1  sticky; parity mismatch.
- pkt_count  out  11  packets completed this run.
- err_beat  out  16  global beat index of the first error; holds 16'hFFFF when no error has occurred.

## Operation
- Derived constants:
  - BPB = BIT_WIDTH/8.
  - LANES = BIT_WIDTH/PATT_WIDTH.
  - exp_beats = ceil(txr_size/BPB). txr_size = 0 counts as 1 beat.
  - valid_bytes_last = txr_size % BPB; a value of 0 means the whole beat is valid.
- State machine:
  - IDLE → RUN on a rising edge of control_reg[1]. The edge is detected with a registered copy of bit 1. Entering RUN clears all counters, errors, chk_done and err_beat.
  - RUN: on each handshake (h2c_tvalid & h2c_tready):
    - Compare the valid lanes against the expected pattern.
    - Increment beat_in_pkt and the global beat counter.
  - RUN, on a tlast handshake:
    - err_len is set if beat_in_pkt+1 ≠ exp_beats.
    - pkt_count increments.
    - beat_in_pkt clears.
    - If pkt_count+1 == num_pkt, go to DONE.
  - RUN, with no tlast: err_len is also set on the handshake where beat_in_pkt+1 == exp_beats. Checking continues until tlast arrives.
  - DONE: chk_done = 1 and h2c_tready = 0. A start edge goes to RUN (cleared as above).
  - num_pkt = 0: a start edge goes directly to DONE and no beats are accepted.
- Expected pattern:
  - Lane j of beat 0 = j.
  - Each accepted beat adds LANES to every lane. Arithmetic is modulo 2^PATT_WIDTH.
  - control_reg[10] = 0: the pattern restarts at j after each tlast.
  - control_reg[10] = 1: after tlast, the next packet's lane 0 = (last valid lane value + 1).
- Last-beat masking:
  - Only bytes below valid_bytes_last are checked, for both data and parity.
  - Lanes partially covered are compared on their covered bytes only.
- h2c_tready:
  - 1 throughout RUN when control_reg[2] = 0.
  - Toggles every cycle starting at 1 when control_reg[2] = 1.
  - 0 in IDLE and DONE.
- A start edge during RUN restarts the run: counters and errors clear, and any in-flight packet is discarded.

## Timing
- Reset values:
  - h2c_tready = 0, chk_busy = 0, chk_done = 0.
  - err_* = 0, pkt_count = 0.
  - err_beat = 16'hFFFF.
  - State = IDLE.
- h2c_tready rises 1 cycle after the start edge is registered, i.e. 2 cycles after control_reg[1] rises.
- Error flags, pkt_count and err_beat are registered and update on the cycle after the offending or final handshake.
- chk_done asserts the cycle after the final tlast handshake, with h2c_tready deasserting in the same cycle.
- Reset asserted mid-run returns everything to reset values on the next edge. A beat presented in that cycle is not counted.
- err_beat captures only the first error. If data, parity and length errors occur in the same beat, all of their flags set together.

## Configuration
- ST_H2C_PARITY_CHK_EN:
  - Defined: per-byte odd-parity check on valid bytes drives err_par.
  - Undefined: h2c_dpar is ignored, err_par is tied 0, and parity logic is removed.

## Structure
- The shared package qdma_tm_pkg holds:
  - state enum {IDLE, RUN, DONE}.
  - control_reg bit-position constants.
  - functions lanes_per_beat() and beats_for_size().
- One sub-module, st_patt_gen, holds the expected-pattern lane register array. Its inputs are advance, restart and continue_from. It is reusable by the C2H generator.

## Test plan
- Reset defaults: hold axi_areset 4 cycles. Then h2c_tready = 0, err_beat = 16'hFFFF, and all flags are 0.
- Clean run, BIT_WIDTH=64, txr_size=20, num_pkt=2:
  - Each packet is 3 beats; beat 2 lanes are 8, 9, {garbage}.
  - Result: pkt_count = 2, chk_done = 1, no errors.
- Corrupt lane 1 of beat 1 (expect 5, drive 6) → err_data = 1 and err_beat = 1 one cycle later.
- txr_size=16, but tlast sent on beat 0 → err_len = 1 and pkt_count = 1.
- With the macro defined, flip h2c_dpar[3] on beat 0 → err_par = 1. With the macro undefined, the same stimulus leaves err_par = 0.
- control_reg[2] = 1 plus continuous mode, txr_size=12, num_pkt=2:
  - h2c_tready alternates.
  - Packet 2 lane 0 = 6.
  - chk_done = 1 with no errors.
